// File: rtl/jtag_master_if.sv
// Local-controller and TAP-pin signal bundle for jtag_master.
// runtest_cycles exists only when JTAG_MASTER_RUNTEST_EN is defined.
interface jtag_master_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  // Request handshake: start acts as valid and is taken only in a cycle with
  // busy=0 and done=0; is_ir/len/data_in (and runtest_cycles) must be stable
  // in that cycle. done is a one-cycle completion pulse that also qualifies
  // data_out. Requests raised while busy (or during done) are dropped.
  logic               start;
  logic               is_ir;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] data_in;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] data_out;
  logic               tck_o;
  logic               tms;
  logic               tdi_o;
  logic               tdo_i;
`ifdef JTAG_MASTER_RUNTEST_EN
  logic [3:0]         runtest_cycles;

  modport master (
    input  start, is_ir, len, data_in, tdo_i, runtest_cycles,
    output busy, done, data_out, tck_o, tms, tdi_o
  );
  modport slave (
    output start, is_ir, len, data_in, tdo_i, runtest_cycles,
    input  busy, done, data_out, tck_o, tms, tdi_o
  );
`else
  modport master (
    input  start, is_ir, len, data_in, tdo_i,
    output busy, done, data_out, tck_o, tms, tdi_o
  );
  modport slave (
    output start, is_ir, len, data_in, tdo_i,
    input  busy, done, data_out, tck_o, tms, tdi_o
  );
`endif
endinterface

// File: rtl/jtag_master.sv
// JTAG host scan engine: one LSB-first IR or DR scan per request, RTI to RTI.
// Optional macro JTAG_MASTER_RUNTEST_EN adds extra Run-Test/Idle TCK pulses.
module jtag_master #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  jtag_master_if.master      bus,
  output logic [3:0]         dbg_state
);
  localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  localparam logic [3:0] ST_INIT    = 4'd0;
  localparam logic [3:0] ST_IDLE    = 4'd1;
  localparam logic [3:0] ST_SEL_DR  = 4'd2;
  localparam logic [3:0] ST_SEL_IR  = 4'd3;
  localparam logic [3:0] ST_CAPTURE = 4'd4;
  localparam logic [3:0] ST_SHIFT   = 4'd5;
  localparam logic [3:0] ST_EXIT1   = 4'd6;
  localparam logic [3:0] ST_UPDATE  = 4'd7;
  localparam logic [3:0] ST_RUNTEST = 4'd8;
  localparam logic [3:0] ST_FINISH  = 4'd9;

  logic [3:0]         state;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               is_ir_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] shreg;
`ifdef JTAG_MASTER_RUNTEST_EN
  logic [3:0]         rt_q;
`endif

  logic               running, tick, rise, fall;
  logic [CNT_W-1:0]   cnt_inc, len_c;
  logic [LEN_W-1:0]   len_eff;

  assign running   = (state != ST_IDLE) && (state != ST_FINISH);
  assign tick      = running && (div_cnt == DIV_LAST);
  assign rise      = tick && !bus.tck_o;
  assign fall      = tick &&  bus.tck_o;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign len_c     = CNT_W'(len_q);
  assign len_eff   = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign dbg_state = state;

  // Each non-idle state owns one or more whole TCK pulses; TMS/TDI for the
  // next pulse are set up on the falling tick that closes the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      div_cnt      <= '0;
      cnt          <= '0;
      is_ir_q      <= 1'b0;
      len_q        <= '0;
      data_q       <= '0;
      shreg        <= '0;
      bus.tck_o    <= 1'b0;
      bus.tms      <= 1'b1;
      bus.tdi_o    <= 1'b0;
      bus.busy     <= 1'b1;
      bus.done     <= 1'b0;
      bus.data_out <= '0;
`ifdef JTAG_MASTER_RUNTEST_EN
      rt_q         <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (tick) begin
        div_cnt   <= '0;
        bus.tck_o <= ~bus.tck_o;
      end else if (running) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end
      if (rise && state == ST_SHIFT) shreg[cnt[IDX_W-1:0]] <= bus.tdo_i;

      case (state)
        ST_INIT: if (fall) begin
          cnt <= cnt_inc;
          if (cnt == CNT_W'(4)) bus.tms <= 1'b0;
          if (cnt == CNT_W'(5)) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        // done is checked so a request coinciding with completion is dropped.
        ST_IDLE: if (bus.start && !bus.done) begin
          is_ir_q  <= bus.is_ir;
          len_q    <= len_eff;
          data_q   <= bus.data_in;
          shreg    <= '0;
          cnt      <= '0;
          bus.busy <= 1'b1;
`ifdef JTAG_MASTER_RUNTEST_EN
          rt_q     <= bus.runtest_cycles;
`endif
          if (len_eff == '0) begin
            state <= ST_FINISH;
          end else begin
            state   <= ST_SEL_DR;
            bus.tms <= 1'b1;
          end
        end
        ST_SEL_DR: if (fall) begin
          state   <= is_ir_q ? ST_SEL_IR : ST_CAPTURE;
          bus.tms <= is_ir_q;
          cnt     <= '0;
        end
        ST_SEL_IR: if (fall) begin
          state   <= ST_CAPTURE;
          bus.tms <= 1'b0;
          cnt     <= '0;
        end
        // Two TMS=0 pulses: into Capture, then Capture -> Shift.
        ST_CAPTURE: if (fall) begin
          if (cnt == '0) begin
            cnt <= cnt_inc;
          end else begin
            state     <= ST_SHIFT;
            cnt       <= '0;
            bus.tdi_o <= data_q[0];
            bus.tms   <= (len_q == LEN_W'(1));
          end
        end
        ST_SHIFT: if (fall) begin
          if (cnt_inc == len_c) begin
            state     <= ST_EXIT1;
            bus.tms   <= 1'b1;
            bus.tdi_o <= 1'b0;
          end else begin
            cnt       <= cnt_inc;
            bus.tdi_o <= data_q[cnt_inc[IDX_W-1:0]];
            bus.tms   <= ((cnt_inc + CNT_W'(1)) == len_c);
          end
        end
        ST_EXIT1: if (fall) begin
          state   <= ST_UPDATE;
          bus.tms <= 1'b0;
        end
        ST_UPDATE: if (fall) begin
`ifdef JTAG_MASTER_RUNTEST_EN
          if (rt_q != 4'd0) begin
            state <= ST_RUNTEST;
            cnt   <= '0;
          end else begin
            state <= ST_FINISH;
          end
`else
          state <= ST_FINISH;
`endif
        end
        ST_RUNTEST: begin
`ifdef JTAG_MASTER_RUNTEST_EN
          if (fall) begin
            if (cnt_inc == CNT_W'(rt_q)) state <= ST_FINISH;
            else                         cnt   <= cnt_inc;
          end
`else
          state <= ST_FINISH;
`endif
        end
        ST_FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          if (len_q != '0) bus.data_out <= shreg;
          state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master against a behavioural TAP (IR capture 0001,
// IDCODE=1 with low byte A1, BYPASS=F as a one-stage TDI->TDO loopback).
module tb_jtag_master;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  localparam int TLR = 0,  RTI = 1,  SDR = 2,  CDR = 3,  SHDR = 4,  E1DR = 5;
  localparam int PDR = 6,  E2DR = 7, UDR = 8,  SIR = 9,  CIR = 10,  SHIR = 11;
  localparam int E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
  localparam logic [3:0]  IR_IDCODE  = 4'h1;
  localparam logic [3:0]  IR_BYPASS  = 4'hF;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_50A1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] dbg_state;
  always #5 clk = ~clk;

  jtag_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // behavioural TAP
  int          tap_st = TLR;
  logic [3:0]  ir = IR_IDCODE;
  logic [3:0]  ir_sh = '0;
  logic [31:0] dr_sh = '0;
  logic        byp = 1'b0;
  logic        tdo_m = 1'b0;
  int          rise_total = 0;
  logic [31:0] tms_log = '0;
  logic [31:0] shift_tdi = '0;
  logic [31:0] shift_tms = '0;
  int          shift_n = 0;
  assign bus.tdo_i = tdo_m;

  function automatic int tap_next(input int s, input logic t);
    case (s)
      TLR:  return t ? TLR  : RTI;
      RTI:  return t ? SDR  : RTI;
      SDR:  return t ? SIR  : CDR;
      CDR:  return t ? E1DR : SHDR;
      SHDR: return t ? E1DR : SHDR;
      E1DR: return t ? UDR  : PDR;
      PDR:  return t ? E2DR : PDR;
      E2DR: return t ? UDR  : SHDR;
      UDR:  return t ? SDR  : RTI;
      SIR:  return t ? TLR  : CIR;
      CIR:  return t ? E1IR : SHIR;
      SHIR: return t ? E1IR : SHIR;
      E1IR: return t ? UIR  : PIR;
      PIR:  return t ? E2IR : PIR;
      E2IR: return t ? UIR  : SHIR;
      default: return t ? SDR : RTI;
    endcase
  endfunction

  always @(posedge bus.tck_o) begin
    rise_total = rise_total + 1;
    tms_log = {tms_log[30:0], bus.tms};
    if ((tap_st == SHDR || tap_st == SHIR) && shift_n < 32) begin
      shift_tdi[shift_n] = bus.tdi_o;
      shift_tms[shift_n] = bus.tms;
      shift_n = shift_n + 1;
    end
    case (tap_st)
      TLR:  ir = IR_IDCODE;
      CDR:  begin
        dr_sh = (ir == IR_IDCODE) ? IDCODE_VAL : 32'h0;
        byp = 1'b0;
        shift_n = 0; shift_tdi = '0; shift_tms = '0;
      end
      SHDR: if (ir == IR_BYPASS) byp = bus.tdi_o;
            else dr_sh = {bus.tdi_o, dr_sh[31:1]};
      CIR:  begin
        ir_sh = 4'b0001;
        shift_n = 0; shift_tdi = '0; shift_tms = '0;
      end
      SHIR: ir_sh = {bus.tdi_o, ir_sh[3:1]};
      UIR:  ir = ir_sh;
      default: ;
    endcase
    tap_st = tap_next(tap_st, bus.tms);
  end

  always @(negedge bus.tck_o) begin
    if (tap_st == SHIR)      tdo_m = ir_sh[0];
    else if (tap_st == SHDR) tdo_m = (ir == IR_BYPASS) ? byp : dr_sh[0];
    else                     tdo_m = 1'b0;
  end

  // cycle / activity monitors
  int cyc = 0;
  int done_total = 0;
  int hi_total = 0;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (bus.done)  done_total = done_total + 1;
    if (bus.tck_o) hi_total = hi_total + 1;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  int rise_base, done_base, hi_base, start_cyc, done_cyc, accept_cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic start_scan(input logic ir_sel, input int len, input logic [15:0] data, input int rt);
    bus.is_ir   = ir_sel;
    bus.len     = LEN_W'(len);
    bus.data_in = data;
`ifdef JTAG_MASTER_RUNTEST_EN
    bus.runtest_cycles = 4'(rt);
`else
    if (rt != 0) $display("note: runtest cycles ignored in this build");
`endif
    rise_base = rise_total;
    done_base = done_total;
    hi_base   = hi_total;
    start_cyc = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(bus.done), 32'd1);
    done_cyc = cyc;
  endtask

  task automatic finish_scan();
    check_eq("busy_low_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq("done_one_clk", 32'(bus.done), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("init_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.is_ir = 1'b0; bus.len = '0; bus.data_in = '0;
`ifdef JTAG_MASTER_RUNTEST_EN
    bus.runtest_cycles = 4'd0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_tck",  32'(bus.tck_o), 32'd0);
    check_eq("rst_tms",  32'(bus.tms), 32'd1);
    check_eq("rst_tdi",  32'(bus.tdi_o), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd1);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_dout", 32'(bus.data_out), 32'd0);
    rise_base = rise_total;
    rst = 1'b0;
    wait_idle(200);
    check_eq("init_pulses", 32'(rise_total - rise_base), 32'd6);
    check_eq("init_tms", tms_log & 32'h3F, 32'h3E);
    check_eq("init_tap_rti", 32'(tap_st), 32'(RTI));
    @(negedge clk);
    check_eq("idle_tck", 32'(bus.tck_o), 32'd0);
    check_eq("idle_tms", 32'(bus.tms), 32'd0);
    check_eq("idle_tdi", 32'(bus.tdi_o), 32'd0);

    // IR scan selecting IDCODE
    start_scan(1'b1, 4, 16'h0001, 0);
    wait_done(400);
    finish_scan();
    check_eq("ir_pulses", 32'(rise_total - rise_base), 32'd10);
    check_eq("ir_nshift", 32'(shift_n), 32'd4);
    check_eq("ir_tdi", shift_tdi, 32'h1);
    check_eq("ir_tms_shift", shift_tms, 32'h8);
    check_eq("ir_capture", 32'(bus.data_out), 32'h0001);
    check_eq("ir_done_count", 32'(done_total - done_base), 32'd1);

    // IDCODE DR read
    start_scan(1'b0, 8, 16'h0000, 0);
    wait_done(400);
    finish_scan();
    check_eq("idcode_pulses", 32'(rise_total - rise_base), 32'd13);
    check_eq("idcode_data", 32'(bus.data_out), 32'h00A1);
    check_eq("idcode_tck_high", 32'(hi_total - hi_base), 32'(13 * CLK_DIV));

    // select BYPASS, then loopback DR scan
    start_scan(1'b1, 4, 16'h000F, 0);
    wait_done(400);
    finish_scan();
    check_eq("bypass_ir_capture", 32'(bus.data_out), 32'h0001);
    start_scan(1'b0, 10, 16'h02A5, 0);
    wait_done(400);
    finish_scan();
    check_eq("loop_pulses", 32'(rise_total - rise_base), 32'd15);
    check_eq("loop_data", 32'(bus.data_out), 32'h014A);
    check_eq("loop_tdi", shift_tdi, 32'h2A5);
    check_eq("loop_tms_shift", shift_tms, 32'h200);

    // START while busy has no effect
    start_scan(1'b0, 8, 16'h00FF, 0);
    repeat (4) @(negedge clk);
    bus.is_ir = 1'b1; bus.len = 5'd3; bus.data_in = 16'h0005; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_done(400);
    finish_scan();
    repeat (10) @(negedge clk);
    check_eq("busy_start_pulses", 32'(rise_total - rise_base), 32'd13);
    check_eq("busy_start_data", 32'(bus.data_out), 32'h00FE);
    check_eq("busy_start_dones", 32'(done_total - done_base), 32'd1);

    // LEN=0: no TCK, DONE 2 CLK after START, DATA_OUT held
    start_scan(1'b0, 0, 16'hFFFF, 0);
    wait_done(50);
    check_eq("len0_latency", 32'(done_cyc - start_cyc), 32'd2);
    finish_scan();
    check_eq("len0_pulses", 32'(rise_total - rise_base), 32'd0);
    check_eq("len0_data", 32'(bus.data_out), 32'h00FE);

    // START during DONE ignored, START in the following cycle accepted
    start_scan(1'b0, 0, 16'h0000, 0);
    wait_done(50);
    bus.start = 1'b1;
    @(negedge clk);
    check_eq("start_in_done_ignored", 32'(bus.busy), 32'd0);
    accept_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(50);
    check_eq("start_after_done", 32'(done_cyc - accept_cyc), 32'd2);
    finish_scan();

    // LEN above MAX_LEN clamps
    start_scan(1'b0, 20, 16'h8001, 0);
    wait_done(600);
    finish_scan();
    check_eq("clamp_pulses", 32'(rise_total - rise_base), 32'd21);
    check_eq("clamp_nshift", 32'(shift_n), 32'd16);
    check_eq("clamp_data", 32'(bus.data_out), 32'h0002);

    // RST at the third shift pulse
    start_scan(1'b0, 8, 16'h0000, 0);
    begin
      int n = 0;
      while (!(tap_st == SHDR && shift_n == 3) && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("rst_at_shift3", 32'(shift_n), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_tck",  32'(bus.tck_o), 32'd0);
    check_eq("abort_tms",  32'(bus.tms), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd1);
    rise_base = rise_total;
    done_base = done_total;
    rst = 1'b0;
    wait_idle(200);
    repeat (5) @(negedge clk);
    check_eq("reinit_pulses", 32'(rise_total - rise_base), 32'd6);
    check_eq("reinit_tms", tms_log & 32'h3F, 32'h3E);
    check_eq("abort_no_done", 32'(done_total - done_base), 32'd0);
    check_eq("reinit_tap_rti", 32'(tap_st), 32'(RTI));

`ifdef JTAG_MASTER_RUNTEST_EN
    start_scan(1'b0, 8, 16'h0000, 3);
    wait_done(600);
    finish_scan();
    check_eq("runtest_pulses", 32'(rise_total - rise_base), 32'd16);
    check_eq("runtest_data", 32'(bus.data_out), 32'h00A1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
